conv_seq: RTL and testbench
===========================

CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 Parameter IMG_W, default 28: input image width, pixels.
REQ-002 Parameter IMG_H, default 28: input image height, pixels.
REQ-003 Parameter OUT_W, default 12: conv output width.
REQ-004 Parameter OUT_H, default 12: conv output height.
REQ-005 Parameter OUT_CH, default 8: conv output channels.
REQ-006 Ports SHALL be exactly as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begin one forward pass
- busy  out  1  pass in progress
- done  out  1  single-cycle pulse, pass complete
- err  out  1  sticky flag, out-of-range output coordinate seen
- img_addr  out  10  image BRAM address {y[4:0],x[4:0]}
- img_rdata  in  32  image BRAM read data, 1-cycle read latency
- conv_in_valid  out  1  pixel valid to conv engine
- conv_in_rdy  in  1  conv engine accepts pixel
- conv_in_data  out  32  pixel value, sign-magnitude fixed point
- conv_in_x  out  5  pixel column
- conv_in_y  out  5  pixel row
- conv_out_rdy  out  1  sequencer accepts conv result
- conv_out_valid  in  1  conv result valid
- conv_out_data  in  32  result value
- conv_out_idx  in  3  result channel
- conv_out_x  in  4  result column
- conv_out_y  in  4  result row
- res_we  out  1  result BRAM write enable
- res_addr  out  11  result BRAM address {idx[2:0],x[3:0],y[3:0]}
- res_wdata  out  32  result BRAM write data

Function
REQ-007 States IDLE, FETCH, PRESENT, DRAIN, DONE; reset state IDLE.
REQ-008 IDLE: start=1 -> FETCH; x=0, y=0, img_addr=0, result count=0, err cleared; busy=1 from next cycle.
REQ-009 start while busy=1 SHALL be ignored.
REQ-010 FETCH lasts exactly one cycle (BRAM latency); next edge captures img_rdata into conv_in_data, asserts conv_in_valid, -> PRESENT.
REQ-011 PRESENT: conv_in_valid, conv_in_data, conv_in_x, conv_in_y held stable until conv_in_rdy=1 is sampled.
REQ-012 On handshake: conv_in_valid deasserted next cycle; x increments, at IMG_W-1 wraps to 0 and y increments; img_addr updated to {y,x} same edge; -> FETCH.
REQ-013 Handshake on pixel (IMG_W-1, IMG_H-1) -> DRAIN, no further image reads.
REQ-014 First conv_in_valid SHALL rise 2 cycles after start; minimum 2 cycles per pixel.
REQ-015 conv_out_rdy=1 in FETCH, PRESENT, DRAIN; 0 in IDLE, DONE; results accepted while pixels still streaming.
REQ-016 Accepted result with conv_out_x<OUT_W and conv_out_y<OUT_H and conv_out_idx<OUT_CH: next cycle res_we=1, res_addr={idx,x,y}, res_wdata=conv_out_data; 11-bit result count increments.
REQ-017 Accepted result with any coordinate out of range: no write, not counted, err set (sticky until next start).
REQ-018 res_we SHALL be high only one cycle per accepted in-range result.
REQ-019 DRAIN: when count reaches OUT_W*OUT_H*OUT_CH (1152) -> DONE; count reaching 1152 before DRAIN is entered -> DONE immediately after last pixel handshake.
REQ-020 Last pixel handshake and last result in same cycle -> final write issued, DONE next cycle.
REQ-021 DONE: done=1 one cycle, busy=0 same cycle, -> IDLE.
REQ-022 No timeout; DRAIN waits indefinitely.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, conv_in_valid=0, conv_out_rdy=0, res_we=0, img_addr=0, res_addr=0, counters=0, data regs=0.
REQ-024 rst_n asserted mid-pass SHALL abandon the pass with no done pulse; next start begins at pixel (0,0).

Verification
REQ-025 start, conv_in_rdy tied 1, model returns 1152 in-range results -> 784 pixel handshakes in raster order x-inner, img_addr 0x000..0x37B, 1152 writes, one done pulse.
REQ-026 conv_in_rdy low 5 cycles on pixel (3,0) -> conv_in_data/x/y stable across stall, no pixel skipped or repeated.
REQ-027 result (idx=2,x=5,y=7,data=0x00018000) -> res_addr=0x257, res_wdata=0x00018000, res_we one cycle.
REQ-028 result x=12 -> no write, err=1, count unchanged, done withheld until 1152 valid results.
REQ-029 rst_n pulsed low at pixel 400 -> all outputs at reset values, no done; new start restarts at img_addr 0.
REQ-030 start pulsed during PRESENT -> no effect on coordinates or state.

Source files
------------

// File: rtl/conv_seq.sv
// -----------------------------------------------------------------------------
// conv_seq
// Sequencer for one forward pass of a convolution engine. It streams every
// pixel of an IMG_W x IMG_H image from an image BRAM into the conv engine in
// raster order (x inner). At the same time it accepts conv results and writes
// the in-range ones into a result BRAM. The pass ends with a single-cycle done
// pulse once every pixel has been handed over and OUT_W*OUT_H*OUT_CH in-range
// results have been written.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            single-cycle pulse that starts a pass (ignored when busy)
//   busy             pass in progress
//   done             single-cycle pulse when the pass completes
//   err              sticky until the next start: a result with an
//                    out-of-range coordinate was seen
//   img_addr         image BRAM address {y[4:0],x[4:0]}
//   img_rdata        image BRAM data, valid one cycle after img_addr changes
//   conv_in_*        pixel stream to the conv engine (valid/rdy handshake)
//   conv_out_*       result stream from the conv engine (valid/rdy handshake)
//   res_we/addr/wdata result BRAM write port, address {idx[2:0],x[3:0],y[3:0]}
// -----------------------------------------------------------------------------
module conv_seq #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int OUT_W  = 12,
  parameter int OUT_H  = 12,
  parameter int OUT_CH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  img_addr,
  input  logic [31:0] img_rdata,
  output logic        conv_in_valid,
  input  logic        conv_in_rdy,
  output logic [31:0] conv_in_data,
  output logic [4:0]  conv_in_x,
  output logic [4:0]  conv_in_y,
  output logic        conv_out_rdy,
  input  logic        conv_out_valid,
  input  logic [31:0] conv_out_data,
  input  logic [2:0]  conv_out_idx,
  input  logic [3:0]  conv_out_x,
  input  logic [3:0]  conv_out_y,
  output logic        res_we,
  output logic [10:0] res_addr,
  output logic [31:0] res_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [4:0]  X_LAST    = 5'(IMG_W - 1);
  localparam logic [4:0]  Y_LAST    = 5'(IMG_H - 1);
  localparam logic [10:0] RES_TOTAL = 11'(OUT_W * OUT_H * OUT_CH);
  localparam logic [31:0] OUT_W_L   = 32'(OUT_W);
  localparam logic [31:0] OUT_H_L   = 32'(OUT_H);
  localparam logic [31:0] OUT_CH_L  = 32'(OUT_CH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [4:0]  x_q;             // coordinate of the pixel being fetched/presented
  logic [4:0]  y_q;
  logic [10:0] cnt_q;           // in-range results written this pass
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        conv_in_valid_q;
  logic [31:0] conv_in_data_q;
  logic [4:0]  conv_in_x_q;
  logic [4:0]  conv_in_y_q;
  logic        conv_out_rdy_q;
  logic        res_we_q;
  logic [10:0] res_addr_q;
  logic [31:0] res_wdata_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        res_accept;
  logic        res_in_range;
  logic        res_hit;
  logic [10:0] cnt_d;
  logic        cnt_full;
  logic        pix_hs;
  logic        last_pix;

  always_comb begin
    res_accept   = conv_out_valid & conv_out_rdy_q;
    res_in_range = (32'(conv_out_x)   < OUT_W_L) &&
                   (32'(conv_out_y)   < OUT_H_L) &&
                   (32'(conv_out_idx) < OUT_CH_L);
    res_hit      = res_accept & res_in_range;
    cnt_d        = cnt_q + {10'd0, res_hit};
    // Looks at the count including a result accepted this cycle, so a final
    // result arriving together with the last pixel handshake still ends the
    // pass on that same edge (its write is issued alongside done).
    cnt_full     = (cnt_d >= RES_TOTAL);
    pix_hs       = conv_in_valid_q & conv_in_rdy;
    last_pix     = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      x_q             <= '0;
      y_q             <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      conv_in_valid_q <= 1'b0;
      conv_in_data_q  <= '0;
      conv_in_x_q     <= '0;
      conv_in_y_q     <= '0;
      conv_out_rdy_q  <= 1'b0;
      res_we_q        <= 1'b0;
      res_addr_q      <= '0;
      res_wdata_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      res_we_q <= 1'b0;

      // Result path runs independently of the pixel stream; conv_out_rdy_q
      // already restricts it to FETCH/PRESENT/DRAIN.
      cnt_q <= cnt_d;
      if (res_accept) begin
        if (res_in_range) begin
          res_we_q    <= 1'b1;
          res_addr_q  <= {conv_out_idx, conv_out_x, conv_out_y};
          res_wdata_q <= conv_out_data;
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q        <= S_FETCH;
            x_q            <= '0;
            y_q            <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b1;
            conv_out_rdy_q <= 1'b1;
          end
        end

        // img_addr has been stable for a full cycle, so the BRAM output now
        // holds the pixel addressed by {y_q,x_q}.
        S_FETCH: begin
          conv_in_data_q  <= img_rdata;
          conv_in_x_q     <= x_q;
          conv_in_y_q     <= y_q;
          conv_in_valid_q <= 1'b1;
          state_q         <= S_PRESENT;
        end

        S_PRESENT: begin
          if (pix_hs) begin
            conv_in_valid_q <= 1'b0;
            if (last_pix) begin
              // Coordinates stay on the last pixel: no further image reads.
              if (cnt_full) begin
                state_q        <= S_DONE;
                busy_q         <= 1'b0;
                done_q         <= 1'b1;
                conv_out_rdy_q <= 1'b0;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + 5'd1;
              end else begin
                x_q <= x_q + 5'd1;
              end
              state_q <= S_FETCH;
            end
          end
        end

        // Waits for the remaining results with no time limit.
        S_DRAIN: begin
          if (cnt_full) begin
            state_q        <= S_DONE;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            conv_out_rdy_q <= 1'b0;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign img_addr      = {y_q, x_q};
  assign conv_in_valid = conv_in_valid_q;
  assign conv_in_data  = conv_in_data_q;
  assign conv_in_x     = conv_in_x_q;
  assign conv_in_y     = conv_in_y_q;
  assign conv_out_rdy  = conv_out_rdy_q;
  assign res_we        = res_we_q;
  assign res_addr      = res_addr_q;
  assign res_wdata     = res_wdata_q;

endmodule

// File: tb/tb_conv_seq.sv
// -----------------------------------------------------------------------------
// tb_conv_seq
// Directed sequence of forward passes with randomized pixel back-pressure,
// randomized result arrival and random image/result data. Expectations come
// from a small reference model: raster-order pixel counter, image memory
// array, and a queue of result items whose in-range ones must each produce
// exactly one write on the following cycle.
// -----------------------------------------------------------------------------
module tb_conv_seq;

  localparam int NPIX = 784;
  localparam int NRES = 1152;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        start          = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  img_addr;
  logic [31:0] img_rdata;
  logic        conv_in_valid;
  logic        conv_in_rdy    = 1'b0;
  logic [31:0] conv_in_data;
  logic [4:0]  conv_in_x;
  logic [4:0]  conv_in_y;
  logic        conv_out_rdy;
  logic        conv_out_valid = 1'b0;
  logic [31:0] conv_out_data  = '0;
  logic [2:0]  conv_out_idx   = '0;
  logic [3:0]  conv_out_x     = '0;
  logic [3:0]  conv_out_y     = '0;
  logic        res_we;
  logic [10:0] res_addr;
  logic [31:0] res_wdata;

  always #5 clk = ~clk;

  // Image BRAM: its address register is the DUT's img_addr register.
  logic [31:0] mem [1024];
  assign img_rdata = mem[img_addr];

  conv_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .img_addr      (img_addr),
    .img_rdata     (img_rdata),
    .conv_in_valid (conv_in_valid),
    .conv_in_rdy   (conv_in_rdy),
    .conv_in_data  (conv_in_data),
    .conv_in_x     (conv_in_x),
    .conv_in_y     (conv_in_y),
    .conv_out_rdy  (conv_out_rdy),
    .conv_out_valid(conv_out_valid),
    .conv_out_data (conv_out_data),
    .conv_out_idx  (conv_out_idx),
    .conv_out_x    (conv_out_x),
    .conv_out_y    (conv_out_y),
    .res_we        (res_we),
    .res_addr      (res_addr),
    .res_wdata     (res_wdata)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [31:0] d;
  } res_t;

  res_t res_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int ex, ey;          // next pixel expected in raster order
  int pix_cnt;         // pixel handshakes this pass
  int mod_cnt;         // in-range results accepted this pass
  int done_cnt;
  bit in_pass = 1'b0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input res_t r);
    return (int'(r.x) < 12) && (int'(r.y) < 12) && (int'(r.idx) < 8);
  endfunction

  // Every (idx,x,y) output position exactly once, shuffled, optionally with
  // two out-of-range items mixed in.
  task automatic build_results(input bit inject);
    res_t it;
    res_t tmp;
    int   j;
    res_q.delete();
    for (int c = 0; c < 8; c++)
      for (int xx = 0; xx < 12; xx++)
        for (int yy = 0; yy < 12; yy++) begin
          it.idx = 3'(c);
          it.x   = 4'(xx);
          it.y   = 4'(yy);
          it.d   = (c == 2 && xx == 5 && yy == 7) ? 32'h00018000 : $urandom();
          res_q.push_back(it);
        end
    for (int i = NRES - 1; i > 0; i--) begin
      j        = $urandom_range(i, 0);
      tmp      = res_q[i];
      res_q[i] = res_q[j];
      res_q[j] = tmp;
    end
    if (inject) begin
      it.idx = 3'($urandom_range(7, 0));
      it.x   = 4'd12;
      it.y   = 4'($urandom_range(11, 0));
      it.d   = $urandom();
      res_q.insert(200, it);
      it.x   = 4'd3;
      it.y   = 4'd13;
      res_q.insert(500, it);
    end
  endtask

  task automatic check_reset_outputs(input string phase);
    chk({phase, "_busy"},  32'(busy), 0);
    chk({phase, "_done"},  32'(done), 0);
    chk({phase, "_err"},   32'(err), 0);
    chk({phase, "_civ"},   32'(conv_in_valid), 0);
    chk({phase, "_cordy"}, 32'(conv_out_rdy), 0);
    chk({phase, "_we"},    32'(res_we), 0);
    chk({phase, "_iaddr"}, 32'(img_addr), 0);
    chk({phase, "_raddr"}, 32'(res_addr), 0);
    chk({phase, "_wdata"}, res_wdata, 0);
    chk({phase, "_cid"},   conv_in_data, 0);
    chk({phase, "_cix"},   32'(conv_in_x), 0);
    chk({phase, "_ciy"},   32'(conv_in_y), 0);
  endtask

  // One forward pass. stop_pix > 0 returns right after that many pixel
  // handshakes, leaving the pass in flight.
  task automatic run_pass(input bit rnd_rdy, input int res_pct, input int stop_pix, input bit poke);
    res_t        cur;
    res_t        wr_item;
    bit          offering, wr_exp, err_n, pend, stalled, poked;
    logic [31:0] pd;
    logic [4:0]  px, py;
    int          stall_left, cond_cyc;
    cur = '0; wr_item = '0; offering = 0; pend = 0; stalled = 0; poked = 0;
    pd = '0; px = '0; py = '0; stall_left = 0; cond_cyc = -1;
    ex = 0; ey = 0; pix_cnt = 0; mod_cnt = 0; done_cnt = 0;

    conv_out_valid = 1'b0;
    conv_in_rdy    = 1'b1;
    start          = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    in_pass = 1'b1;
    err_exp = 1'b0;
    chk("start_busy",       32'(busy), 1);
    chk("start_cordy",      32'(conv_out_rdy), 1);
    chk("start_err_clr",    32'(err), 0);
    chk("start_iaddr",      32'(img_addr), 0);
    chk("start_valid_lat1", 32'(conv_in_valid), 0);
    @(posedge clk); #1;
    chk("start_valid_lat2", 32'(conv_in_valid), 1);
    if (rnd_rdy) conv_in_rdy = ($urandom_range(99, 0) < 70);

    for (int cyc = 0; cyc < 20000; cyc++) begin
      // ---- before the edge: observe handshakes that this edge completes
      wr_exp = 1'b0;
      err_n  = err_exp;
      if (conv_in_valid && conv_in_rdy) begin
        chk("pix_x",    32'(conv_in_x), 32'(ex));
        chk("pix_y",    32'(conv_in_y), 32'(ey));
        chk("pix_addr", 32'(img_addr),  32'(ey * 32 + ex));
        chk("pix_data", conv_in_data,   mem[(ey * 32 + ex) % 1024]);
        pix_cnt++;
        if (ex == 27) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      if (conv_out_valid && conv_out_rdy) begin
        if (in_range(cur)) begin
          wr_exp  = 1'b1;
          wr_item = cur;
          mod_cnt++;
        end else begin
          err_n = 1'b1;
        end
        offering = 1'b0;
      end
      pend = conv_in_valid && !conv_in_rdy;
      if (pend) begin
        pd = conv_in_data;
        px = conv_in_x;
        py = conv_in_y;
      end
      if (pix_cnt == NPIX && mod_cnt == NRES && cond_cyc < 0) cond_cyc = cyc;

      @(posedge clk); #1;
      start = 1'b0;

      // ---- after the edge: check registered consequences
      chk("res_we", 32'(res_we), 32'(wr_exp));
      if (wr_exp) begin
        chk("res_addr",  32'(res_addr), 32'({wr_item.idx, wr_item.x, wr_item.y}));
        chk("res_wdata", res_wdata, wr_item.d);
        if (wr_item.idx == 3'd2 && wr_item.x == 4'd5 && wr_item.y == 4'd7) begin
          chk("dir_addr",  32'(res_addr), 32'h257);
          chk("dir_wdata", res_wdata, 32'h00018000);
        end
      end
      chk("err", 32'(err), 32'(err_n));
      err_exp = err_n;
      if (pend) begin
        chk("stall_valid", 32'(conv_in_valid), 1);
        chk("stall_data",  conv_in_data, pd);
        chk("stall_x",     32'(conv_in_x), 32'(px));
        chk("stall_y",     32'(conv_in_y), 32'(py));
      end
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_pix", pix_cnt, NPIX);
        chk("done_res", mod_cnt, NRES);
        in_pass = 1'b0;
      end
      chk("busy",  32'(busy), 32'(in_pass));
      chk("cordy", 32'(conv_out_rdy), 32'(in_pass));
      if (!in_pass) break;
      if (cond_cyc >= 0 && cyc - cond_cyc >= 2) begin
        chk("done_late", 32'(done), 1);
        break;
      end
      if (stop_pix > 0 && pix_cnt >= stop_pix) return;

      // ---- drive inputs for the next cycle
      if (stall_left > 0) begin
        conv_in_rdy = 1'b0;
        stall_left--;
      end else if (rnd_rdy && !stalled && conv_in_valid && ex == 3 && ey == 0) begin
        conv_in_rdy = 1'b0;
        stall_left  = 4;
        stalled     = 1'b1;
      end else if (rnd_rdy) begin
        conv_in_rdy = ($urandom_range(99, 0) < 70);
      end else begin
        conv_in_rdy = 1'b1;
      end
      if (!offering && res_q.size() > 0 && $urandom_range(99, 0) < res_pct) begin
        cur      = res_q.pop_front();
        offering = 1'b1;
      end
      conv_out_valid = offering;
      if (offering) begin
        {conv_out_idx, conv_out_x, conv_out_y, conv_out_data} = {cur.idx, cur.x, cur.y, cur.d};
      end else begin
        conv_out_idx  = 3'($urandom());
        conv_out_x    = 4'($urandom());
        conv_out_y    = 4'($urandom());
        conv_out_data = $urandom();
      end
      if (poke && !poked && pix_cnt == 10 && conv_in_valid) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end

    conv_out_valid = 1'b0;
    conv_in_rdy    = 1'b0;
    if (stop_pix == 0) begin
      chk("done_count", done_cnt, 1);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 0);
      chk("idle_busy",  32'(busy), 0);
      chk("idle_cordy", 32'(conv_out_rdy), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy0",  32'(busy), 0);
    chk("idle_cordy0", 32'(conv_out_rdy), 0);
    $display("pass 0: reset state checked");

    // Back-pressure free pixel stream, slow results: ends from DRAIN.
    build_results(1'b0);
    run_pass(1'b0, 40, 0, 1'b0);
    $display("pass 1: rdy tied high, %0d pixels, %0d results, %0d done", pix_cnt, mod_cnt, done_cnt);

    // Random back-pressure, 5-cycle stall on (3,0), out-of-range results,
    // stray start while presenting.
    build_results(1'b1);
    run_pass(1'b1, 60, 0, 1'b1);
    $display("pass 2: random rdy, %0d pixels, %0d results, err=%0b", pix_cnt, mod_cnt, err_exp);

    // Reset in the middle of a pass.
    build_results(1'b1);
    run_pass(1'b1, 60, 400, 1'b0);
    conv_out_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    in_pass = 1'b0;
    err_exp = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_done", 32'(done), 0);
      chk("rst_hold_busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("pass 3: reset after %0d pixels", pix_cnt);

    // Restart from (0,0); results arrive faster than pixels, so the count
    // completes before the last pixel handshake.
    build_results(1'b0);
    run_pass(1'b1, 100, 0, 1'b0);
    $display("pass 4: restart, %0d pixels, %0d results, %0d done", pix_cnt, mod_cnt, done_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
